// File: rtl/intr_edge_pending.sv
// Slow-domain interrupt front end: rising-edge capture into pending bits,
// enable-masked aggregate irq, one-at-a-time claim/complete, lost-edge count.
module intr_edge_pending #(
    parameter int INTR_WIDTH = 8,
    parameter int ID_WIDTH   = 3,
    parameter int OVF_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [INTR_WIDTH-1:0] intr_in,
    input  logic [INTR_WIDTH-1:0] intr_en,
    output logic                  irq,
    output logic [INTR_WIDTH-1:0] pending,
    input  logic                  claim_req,
    output logic                  claim_ack,
    output logic [ID_WIDTH-1:0]   claim_id,
    output logic                  claim_none,
    input  logic                  complete_req,
    input  logic [ID_WIDTH-1:0]   complete_id,
    output logic                  complete_err,
    output logic [OVF_WIDTH-1:0]  ovf_cnt
);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t                r_state;
    logic [INTR_WIDTH-1:0] r_prev;
    logic [INTR_WIDTH-1:0] r_pending;
    logic [ID_WIDTH-1:0]   r_svc_id;

    logic [INTR_WIDTH-1:0] w_edge;
    logic [INTR_WIDTH-1:0] w_elig;
    logic [INTR_WIDTH-1:0] w_clr;
    logic [INTR_WIDTH-1:0] w_lost;
    logic [ID_WIDTH-1:0]   w_id;
    logic                  w_found;
    logic                  w_grant;
    logic                  w_cmp_ok;
    logic [OVF_WIDTH-1:0]  w_ovf_nxt;

    assign w_edge   = intr_in & ~r_prev;
    assign w_elig   = r_pending & intr_en;
    assign w_found  = |w_elig;
    assign w_grant  = claim_req && (r_state == S_IDLE) && w_found;
    assign w_cmp_ok = complete_req && (r_state == S_BUSY)
                      && (complete_id == r_svc_id);
    assign pending  = r_pending;

    // Scan downward so the lowest eligible index is the one left standing.
    always_comb begin
        w_id = '0;
        for (int i = INTR_WIDTH - 1; i >= 0; i--) begin
            if (w_elig[i]) w_id = ID_WIDTH'(i);
        end
    end

    always_comb begin
        w_clr = '0;
        if (w_grant) w_clr[w_id] = 1'b1;
    end

    // A bit being claimed this cycle absorbs its new edge instead of losing it.
    assign w_lost = w_edge & r_pending & ~w_clr;

    always_comb begin
        w_ovf_nxt = ovf_cnt;
        for (int i = 0; i < INTR_WIDTH; i++) begin
            if (w_lost[i] && (w_ovf_nxt != '1))
                w_ovf_nxt = w_ovf_nxt + OVF_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_prev       <= '0;
            r_pending    <= '0;
            r_svc_id     <= '0;
            irq          <= 1'b0;
            claim_ack    <= 1'b0;
            claim_id     <= '0;
            claim_none   <= 1'b0;
            complete_err <= 1'b0;
            ovf_cnt      <= '0;
        end else begin
            r_prev     <= intr_in;
            r_pending  <= (r_pending & ~w_clr) | w_edge;
            ovf_cnt    <= w_ovf_nxt;
            claim_ack  <= claim_req;
            claim_none <= claim_req && !w_grant;
            claim_id   <= w_grant ? w_id : '0;
            irq        <= (r_state == S_IDLE) && !w_grant && w_found;
            if (complete_req && !w_cmp_ok) complete_err <= 1'b1;
            if (r_state == S_IDLE) begin
                if (w_grant) begin
                    r_state  <= S_BUSY;
                    r_svc_id <= w_id;
                end
            end else begin
                if (w_cmp_ok) r_state <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_intr_edge_pending.sv
// Directed bench for intr_edge_pending with a per-cycle reference model
// and literal checkpoints along the stimulus.
module tb_intr_edge_pending;

    localparam int W   = 8;
    localparam int IW  = 3;
    localparam int OW  = 8;
    localparam int MAX = (1 << OW) - 1;

    logic          clk = 1'b0;
    logic          resetn;
    logic [W-1:0]  intr_in = '0;
    logic [W-1:0]  intr_en = '0;
    logic          irq;
    logic [W-1:0]  pending;
    logic          claim_req = 1'b0;
    logic          claim_ack;
    logic [IW-1:0] claim_id;
    logic          claim_none;
    logic          complete_req = 1'b0;
    logic [IW-1:0] complete_id = '0;
    logic          complete_err;
    logic [OW-1:0] ovf_cnt;

    int n_chk = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    intr_edge_pending #(
        .INTR_WIDTH(W),
        .ID_WIDTH  (IW),
        .OVF_WIDTH (OW)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .intr_in     (intr_in),
        .intr_en     (intr_en),
        .irq         (irq),
        .pending     (pending),
        .claim_req   (claim_req),
        .claim_ack   (claim_ack),
        .claim_id    (claim_id),
        .claim_none  (claim_none),
        .complete_req(complete_req),
        .complete_id (complete_id),
        .complete_err(complete_err),
        .ovf_cnt     (ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Reference model: state of the interrupt controller in plain terms.
    bit [W-1:0] m_pend = '0;
    bit [W-1:0] m_prev = '0;
    bit         m_busy = 0;
    int         m_svc = 0;
    bit         m_irq = 0;
    bit         m_ack = 0;
    int         m_id = 0;
    bit         m_none = 0;
    bit         m_err = 0;
    int         m_ovf = 0;

    always @(posedge clk or negedge resetn) begin : model
        bit [W-1:0] elig;
        bit         grant;
        int         gid;
        bit         e;
        bit         c;
        if (!resetn) begin
            m_pend = '0; m_prev = '0; m_busy = 0; m_svc = 0;
            m_irq = 0; m_ack = 0; m_id = 0; m_none = 0;
            m_err = 0; m_ovf = 0;
        end else begin
            elig  = m_pend & intr_en;
            grant = 0;
            gid   = 0;
            if (claim_req && !m_busy) begin
                for (int i = W - 1; i >= 0; i--) begin
                    if (elig[i]) begin
                        grant = 1;
                        gid   = i;
                    end
                end
            end
            m_irq  = !m_busy && !claim_req && (elig != 0);
            m_ack  = claim_req;
            m_none = claim_req && !grant;
            m_id   = grant ? gid : 0;
            if (complete_req) begin
                if (m_busy && int'(complete_id) == m_svc) m_busy = 0;
                else m_err = 1;
            end
            if (grant) begin
                m_busy = 1;
                m_svc  = gid;
            end
            for (int i = 0; i < W; i++) begin
                e = intr_in[i] && !m_prev[i];
                c = grant && (gid == i);
                if (e) begin
                    if (m_pend[i] && !c && m_ovf < MAX) m_ovf++;
                    m_pend[i] = 1;
                end else if (c) begin
                    m_pend[i] = 0;
                end
            end
            m_prev = intr_in;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("irq", 32'(irq), 32'(m_irq));
            chk("pending", 32'(pending), 32'(m_pend));
            chk("claim_ack", 32'(claim_ack), 32'(m_ack));
            chk("claim_id", 32'(claim_id), 32'(m_id));
            chk("claim_none", 32'(claim_none), 32'(m_none));
            chk("complete_err", 32'(complete_err), 32'(m_err));
            chk("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic pulse(input logic [W-1:0] m);
        intr_in = m;
        step();
        intr_in = '0;
        step();
    endtask

    task automatic claim();
        claim_req = 1'b1;
        step();
        claim_req = 1'b0;
    endtask

    task automatic complete(input int id);
        complete_req = 1'b1;
        complete_id  = IW'(id);
        step();
        complete_req = 1'b0;
    endtask

    initial begin
        resetn = 1'b1;
        #1;
        resetn  = 1'b0;
        intr_en = 8'hFF;
        intr_in = 8'h01;
        step();
        check_en = 1'b1;
        chk("rst_irq", 32'(irq), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_ovf", 32'(ovf_cnt), 0);

        // Input already high when reset releases gives a single edge.
        resetn = 1'b1;
        step();
        chk("t1_pend", 32'(pending), 32'h01);
        chk("t1_irq0", 32'(irq), 0);
        step();
        chk("t1_irq1", 32'(irq), 1);
        step();
        chk("t1_noedge", 32'(pending), 32'h01);
        claim();
        chk("t1_id", 32'(claim_id), 0);
        chk("t1_clr", 32'(pending), 0);
        complete(0);
        intr_in = '0;
        step();
        chk("t1_err", 32'(complete_err), 0);

        // Priority: bits 5 and 2 together.
        pulse(8'h24);
        chk("t2_irq", 32'(irq), 1);
        claim();
        chk("t2_ack", 32'(claim_ack), 1);
        chk("t2_id", 32'(claim_id), 2);
        chk("t2_pend", 32'(pending), 32'h20);
        chk("t2_irq0", 32'(irq), 0);
        complete(2);
        step();
        chk("t2_irq1", 32'(irq), 1);
        claim();
        chk("t2_id5", 32'(claim_id), 5);
        complete(5);
        step();

        // Masked source still latches but cannot be claimed.
        intr_en = 8'h00;
        pulse(8'h08);
        chk("t3_pend", 32'(pending), 32'h08);
        chk("t3_irq", 32'(irq), 0);
        claim();
        chk("t3_ack", 32'(claim_ack), 1);
        chk("t3_none", 32'(claim_none), 1);
        intr_en = 8'h08;
        step(2);
        chk("t3_irq1", 32'(irq), 1);
        claim();
        chk("t3_id", 32'(claim_id), 3);
        complete(3);
        intr_en = 8'hFF;
        step();

        // Re-edge of serviced source during claim; wrong-id complete.
        pulse(8'h02);
        claim_req = 1'b1;
        intr_in   = 8'h02;
        step();
        claim_req = 1'b0;
        intr_in   = '0;
        chk("t5_id", 32'(claim_id), 1);
        chk("t5_pend", 32'(pending), 32'h02);
        chk("t5_ovf", 32'(ovf_cnt), 0);
        complete(6);
        chk("t5_err", 32'(complete_err), 1);
        claim();
        chk("t5_busynone", 32'(claim_none), 1);
        step();
        chk("t5_busyirq", 32'(irq), 0);
        complete(1);
        step();
        chk("t5_irq1", 32'(irq), 1);
        claim();
        chk("t5_id1", 32'(claim_id), 1);
        complete(1);
        step();

        // Overrun saturation.
        pulse(8'h10);
        for (int k = 0; k < 300; k++) pulse(8'h10);
        chk("t4_ovf", 32'(ovf_cnt), MAX);
        chk("t4_pend", 32'(pending), 32'h10);
        claim();
        chk("t4_id", 32'(claim_id), 4);
        complete(4);
        step();

        // Asynchronous reset during service with everything pending.
        intr_in = 8'hFF;
        step();
        claim();
        chk("t6_id", 32'(claim_id), 0);
        intr_in = 8'hFE;
        step();
        intr_in = 8'hFF;
        step();
        chk("t6_pend", 32'(pending), 32'hFF);
        resetn = 1'b0;
        #1;
        chk("t6_rpend", 32'(pending), 0);
        chk("t6_rovf", 32'(ovf_cnt), 0);
        chk("t6_rerr", 32'(complete_err), 0);
        chk("t6_rirq", 32'(irq), 0);
        step();
        resetn = 1'b1;
        step();
        chk("t6_pend2", 32'(pending), 32'hFF);
        chk("t6_ovf2", 32'(ovf_cnt), 0);
        step();
        chk("t6_irq", 32'(irq), 1);
        chk("t6_ovf3", 32'(ovf_cnt), 0);

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
